// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared types and constants for the reg_file_hs register file.
//               - rsp_t        : default response word {data, err} (8-bit data)
//               - slot_state_t : response slot state encoding
//               - reset-value constants for entries 2 (UART cfg) and 3 (clkdiv)
//               - even_parity  : parity helper for data up to 64 bits
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    // Default reset contents of the exported configuration entries.
    localparam logic [7:0] c_REG2_RST_DEF = 8'h81;
    localparam logic [7:0] c_REG3_RST_DEF = 8'h20;

    // Widest data word the parity helper accepts; callers zero-extend,
    // which does not change the XOR result.
    localparam int c_PAR_MAX_W = 64;

    // Response word for the default 8-bit configuration. Wider builds pass
    // their own struct of the same shape to the response slot.
    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } rsp_t;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Even-parity bit: makes the total number of ones (data + bit) even.
    function automatic logic even_parity(input logic [c_PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_hs_if
// Description : Request/response bus of the register file.
//               Request  : req_valid/req_ready handshake carrying
//                          req_write, req_addr, req_wdata.
//               Response : rsp_valid/rsp_ready handshake carrying
//                          rsp_data, rsp_err.
//               modport master : command decoder side
//               modport slave  : register file side
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_hs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_WIDTH  = 8
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [MEM_WIDTH-1:0]  req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [MEM_WIDTH-1:0]  rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/reg_file_rsp_slot.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_rsp_slot
// Description : One-entry valid/ready buffer for response words.
//               Accepts a new word in the same cycle the held one is
//               consumed, so a continuously-ready sink sees one word per
//               cycle with no bubbles.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_in_valid      - producer has a word
//               o_in_ready      - slot can take a word (empty or draining)
//               i_in_data       - word to store
//               o_out_valid     - slot holds a word (registered state)
//               i_out_ready     - sink consumes the held word
//               o_out_data      - held word, stable until consumed
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_rsp_slot
    import reg_file_pkg::*;
#(
    parameter type T = rsp_t
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_in_valid,
    output logic      o_in_ready,
    input  wire T     i_in_data,
    output logic      o_out_valid,
    input  wire logic i_out_ready,
    output T          o_out_data
);

    slot_state_t r_state;
    T            r_data;

    assign o_out_valid = (r_state == SLOT_FULL);
    assign o_in_ready  = (r_state == SLOT_EMPTY) || i_out_ready;
    assign o_out_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (i_in_valid) begin
                        r_state <= SLOT_FULL;
                        r_data  <= i_in_data;
                    end
                end
                SLOT_FULL: begin
                    if (i_out_ready) begin
                        if (i_in_valid) begin
                            // Consume and reload in one edge.
                            r_data <= i_in_data;
                        end else begin
                            r_state <= SLOT_EMPTY;
                        end
                    end
                end
                default: r_state <= SLOT_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_hs.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_hs
// Description : Register file for the command/response path.
//               - valid/ready request port (bus.slave), one response per
//                 accepted request, buffered in a one-entry slot
//               - NUM_OPS operand channels with latched read addresses
//               - live exports of entry 2 (REG2, UART cfg) and 3 (REG3, clkdiv)
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus       - request/response interface (slave modport)
//               op_en     - 1: operands use latched addresses, 0: entry i
//               op_sel    - per-channel address latch strobe
//               op_addr   - address loaded into strobed channels
//               op_data   - operand i at [i*MEM_WIDTH +: MEM_WIDTH]
//               REG2/REG3 - contents of entries 2 and 3
// Config      : REG_FILE_PARITY_EN - store an even-parity bit per entry and
//               flag rsp_err on read mismatch (data still returned).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_hs
    import reg_file_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 4,
    parameter int                   MEM_DEPTH  = 16,
    parameter int                   MEM_WIDTH  = 8,
    parameter int                   NUM_OPS    = 2,
    parameter logic [MEM_WIDTH-1:0] REG2_RST   = MEM_WIDTH'(c_REG2_RST_DEF),
    parameter logic [MEM_WIDTH-1:0] REG3_RST   = MEM_WIDTH'(c_REG3_RST_DEF)
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    reg_file_hs_if.slave                        bus,
    input  wire logic                           op_en,
    input  wire logic [NUM_OPS-1:0]             op_sel,
    input  wire logic [ADDR_WIDTH-1:0]          op_addr,
    output logic      [NUM_OPS*MEM_WIDTH-1:0]   op_data,
    output logic      [MEM_WIDTH-1:0]           REG2,
    output logic      [MEM_WIDTH-1:0]           REG3
);

    typedef struct packed {
        logic [MEM_WIDTH-1:0] data;
        logic                 err;
    } rsp_word_t;

    logic [MEM_WIDTH-1:0]  r_mem     [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] r_op_addr [NUM_OPS];

    logic      w_req_ready;
    logic      w_rsp_valid;
    logic      w_accept;
    logic      w_in_range;
    logic      w_op_in_range;
    logic      w_par_bad;
    rsp_word_t w_rsp;
    rsp_word_t w_slot_out;

    function automatic logic [MEM_WIDTH-1:0] f_rst_value(input int idx);
        if (idx == 2) begin
            return REG2_RST;
        end else if (idx == 3) begin
            return REG3_RST;
        end
        return '0;
    endfunction

    // MEM_DEPTH may be smaller than the address space, so range checks are
    // explicit rather than implied by the address width.
    assign w_in_range    = (32'(bus.req_addr) < MEM_DEPTH);
    assign w_op_in_range = (32'(op_addr) < MEM_DEPTH);
    assign w_accept      = bus.req_valid && w_req_ready;

`ifdef REG_FILE_PARITY_EN
    logic [MEM_DEPTH-1:0] r_par;

    assign w_par_bad = w_in_range &&
        (r_par[bus.req_addr] != even_parity(c_PAR_MAX_W'(r_mem[bus.req_addr])));
`else
    assign w_par_bad = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= f_rst_value(i);
`ifdef REG_FILE_PARITY_EN
                r_par[i] <= even_parity(c_PAR_MAX_W'(f_rst_value(i)));
`endif
            end
        end else if (w_accept && bus.req_write && w_in_range) begin
            r_mem[bus.req_addr] <= bus.req_wdata;
`ifdef REG_FILE_PARITY_EN
            r_par[bus.req_addr] <= even_parity(c_PAR_MAX_W'(bus.req_wdata));
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Response word for the request currently on the bus. Reads see the
    // array before the accept edge; the single port rules out a same-edge
    // write to the entry being read.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rsp     = '0;
        w_rsp.err = !w_in_range;
        if (!bus.req_write && w_in_range) begin
            w_rsp.data = r_mem[bus.req_addr];
            w_rsp.err  = w_par_bad;
        end
    end

    reg_file_rsp_slot #(
        .T (rsp_word_t)
    ) u_rsp_slot (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (bus.req_valid),
        .o_in_ready  (w_req_ready),
        .i_in_data   (w_rsp),
        .o_out_valid (w_rsp_valid),
        .i_out_ready (bus.rsp_ready),
        .o_out_data  (w_slot_out)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = w_slot_out.data;
    assign bus.rsp_err   = w_slot_out.err;

    // ------------------------------------------------------------------------
    // Operand address latches. Out-of-range addresses are ignored so every
    // latched address always indexes a real entry.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                r_op_addr[i] <= ADDR_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (op_sel[i] && w_op_in_range) begin
                    r_op_addr[i] <= op_addr;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_OPS; g++) begin : g_op_lane
            assign op_data[g*MEM_WIDTH +: MEM_WIDTH] =
                op_en ? r_mem[r_op_addr[g]] : r_mem[g];
        end

        if (MEM_DEPTH > 2) begin : g_reg2
            assign REG2 = r_mem[2];
        end else begin : g_reg2_none
            assign REG2 = '0;
        end

        if (MEM_DEPTH > 3) begin : g_reg3
            assign REG3 = r_mem[3];
        end else begin : g_reg3_none
            assign REG3 = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_hs
// Description : Self-checking bench for reg_file_hs (MEM_DEPTH=12, so the
//               top of the 4-bit address space is out of range). Expected
//               responses are queued at request acceptance and compared by a
//               monitor when each response is consumed.
//               Parity checks are built when REG_FILE_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_hs;

    localparam int AW    = 4;
    localparam int DEPTH = 12;
    localparam int W     = 8;
    localparam int NOPS  = 2;

    logic                clk;
    logic                rst;
    logic                op_en;
    logic [NOPS-1:0]     op_sel;
    logic [AW-1:0]       op_addr;
    logic [NOPS*W-1:0]   op_data;
    logic [W-1:0]        reg2;
    logic [W-1:0]        reg3;

    reg_file_hs_if #(.ADDR_WIDTH(AW), .MEM_WIDTH(W)) bus ();

    reg_file_hs #(
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH),
        .MEM_WIDTH  (W),
        .NUM_OPS    (NOPS),
        .REG2_RST   (8'h81),
        .REG3_RST   (8'h20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .op_en   (op_en),
        .op_sel  (op_sel),
        .op_addr (op_addr),
        .op_data (op_data),
        .REG2    (reg2),
        .REG3    (reg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_push   = 0;
    int   n_rsp    = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request; queue its expected response at acceptance.
    // 'waits' reports how many cycles the request was held off.
    task automatic do_req(input logic wr, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic [W-1:0] ed,
                          input logic ee, output int waits);
        waits = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (bus.req_ready === 1'b1) begin
            exp_q.push_back('{ed, ee});
            n_push++;
        end else begin
            n_checks++;
            n_err++;
            $error("FAIL accept_timeout: addr=%0h never accepted", a);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Scoreboard: compare every consumed response with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $error("FAIL rsp_unexpected: data=%0h err=%0b", bus.rsp_data, bus.rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rsp%0d_data", n_rsp), 32'(bus.rsp_data), 32'(e.d));
                    check($sformatf("rsp%0d_err", n_rsp), 32'(bus.rsp_err), 32'(e.e));
                end
                n_rsp++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int w1;
`ifdef REG_FILE_PARITY_EN
        logic pbit;
`endif
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        op_en         = 1'b0;
        op_sel        = '0;
        op_addr       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        check("rst_rsp_err", 32'(bus.rsp_err), 0);
        check("rst_req_ready", 32'(bus.req_ready), 1);
        check("rst_reg2", 32'(reg2), 32'h81);
        check("rst_reg3", 32'(reg3), 32'h20);
        check("rst_op_data", 32'(op_data), 32'h0000);
        op_en = 1'b1;
        #1;
        check("rst_op_latched", 32'(op_data), 32'h0000);
        op_en = 1'b0;

        // Reads of the reset-valued configuration entries
        bus.rsp_ready = 1'b1;
        do_req(1'b0, 4'd2, 8'h00, 8'h81, 1'b0, w0);
        do_req(1'b0, 4'd3, 8'h00, 8'h20, 1'b0, w1);

        // Write then read the same address back-to-back
        do_req(1'b1, 4'd7, 8'h5A, 8'h00, 1'b0, w0);
        check("b2b_rsp_valid_wr", 32'(bus.rsp_valid), 1);
        do_req(1'b0, 4'd7, 8'h00, 8'h5A, 1'b0, w1);
        check("b2b_rsp_valid_rd", 32'(bus.rsp_valid), 1);
        check("b2b_no_bubble", 32'(w0 + w1), 0);
        tick();

        // Stall: hold rsp_ready low with a response pending
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 4'd2, 8'h00, 8'h81, 1'b0, w0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_req_ready", i), 32'(bus.req_ready), 0);
            check($sformatf("stall%0d_rsp_valid", i), 32'(bus.rsp_valid), 1);
            check($sformatf("stall%0d_rsp_data", i), 32'(bus.rsp_data), 32'h81);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        #1;
        check("release_req_ready", 32'(bus.req_ready), 1);
        exp_q.push_back('{8'h20, 1'b0});
        n_push++;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        tick();

        // Operand latches
        op_sel  = 2'b11;
        op_addr = 4'd4;
        tick();
        op_sel = 2'b00;
        do_req(1'b1, 4'd4, 8'h33, 8'h00, 1'b0, w0);
        op_en = 1'b1;
        #1;
        check("op_both_lanes", 32'(op_data), 32'h3333);
        op_en = 1'b0;
        #1;
        check("op_direct", 32'(op_data), 32'h0000);
        op_en   = 1'b1;
        op_sel  = 2'b01;
        op_addr = 4'd13;
        tick();
        check("op_oor_ignored", 32'(op_data), 32'h3333);
        op_sel  = 2'b10;
        op_addr = 4'd7;
        tick();
        check("op_single_strobe", 32'(op_data), 32'h5A33);
        op_sel  = 2'b01;
        op_addr = 4'd12;
        tick();
        check("op_boundary_ignored", 32'(op_data), 32'h5A33);
        op_sel = 2'b00;
        op_en  = 1'b0;

        // Exported configuration entries
        do_req(1'b1, 4'd3, 8'h99, 8'h00, 1'b0, w0);
        check("reg3_written", 32'(reg3), 32'h99);
        check("reg2_kept", 32'(reg2), 32'h81);

        // Out-of-range addresses
        do_req(1'b1, 4'd13, 8'hEE, 8'h00, 1'b1, w0);
        do_req(1'b0, 4'd13, 8'h00, 8'h00, 1'b1, w0);
        do_req(1'b1, 4'd12, 8'hEE, 8'h00, 1'b1, w0);
        do_req(1'b0, 4'd1, 8'h00, 8'h00, 1'b0, w0);
        do_req(1'b0, 4'd5, 8'h00, 8'h00, 1'b0, w0);
        do_req(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, w0);
        do_req(1'b1, 4'd11, 8'h11, 8'h00, 1'b0, w0);
        do_req(1'b0, 4'd11, 8'h00, 8'h11, 1'b0, w0);
        check("oor_reg2", 32'(reg2), 32'h81);
        check("oor_reg3", 32'(reg3), 32'h99);

`ifdef REG_FILE_PARITY_EN
        // Corrupt the stored parity of entry 5 (data 0)
        pbit = dut.r_par[5];
        force dut.r_par[5] = ~pbit;
        do_req(1'b0, 4'd5, 8'h00, 8'h00, 1'b1, w0);
        do_req(1'b0, 4'd7, 8'h00, 8'h5A, 1'b0, w0);
        release dut.r_par[5];
`endif
        tick();
        tick();

        // Reset with a response pending: it is discarded
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 4'd2, 8'h00, 8'h81, 1'b0, w0);
        check("pre_rst_rsp_valid", 32'(bus.rsp_valid), 1);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            n_push--;
        end
        rst = 1'b1;
        tick();
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("midrst_rsp_data", 32'(bus.rsp_data), 0);
        rst = 1'b0;
        check("midrst_reg3", 32'(reg3), 32'h20);
        bus.rsp_ready = 1'b1;
        do_req(1'b0, 4'd7, 8'h00, 8'h00, 1'b0, w0);
        do_req(1'b0, 4'd3, 8'h00, 8'h20, 1'b0, w0);
        repeat (4) tick();

        check("sb_queue_empty", 32'(exp_q.size()), 0);
        check("sb_rsp_count", 32'(n_rsp), 32'(n_push));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
